// File: rtl/matvec_mac4_seq.sv
`default_nettype none
// ============================================================================
//  Module      : matvec_mac4_seq
//  Description : Operand sequencer for a four-lane Q2.14 mac4 group; computes
//                y = W*x row by row and streams saturated results.
//  Revision    : 1.0 - initial release
// ============================================================================
module matvec_mac4_seq #(
   parameter int DATA_WIDTH = 16,
   parameter int VEC_LEN    = 64,
   parameter int ROWS       = 64,
   parameter int ACC_WIDTH  = 32,
   localparam int c_words   = VEC_LEN / 4,
   localparam int c_aw      = (ROWS * c_words > 1) ? $clog2(ROWS * c_words) : 1,
   localparam int c_kw      = (c_words > 1) ? $clog2(c_words) : 1,
   localparam int c_rw      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [c_aw-1:0]         w_addr,
   input  logic [4*DATA_WIDTH-1:0] w_rdata,
   output logic [c_kw-1:0]         x_addr,
   input  logic [4*DATA_WIDTH-1:0] x_rdata,
   output logic [4*DATA_WIDTH-1:0] mac_a,
   output logic [4*DATA_WIDTH-1:0] mac_b,
   input  logic [2*DATA_WIDTH-1:0] mac_result,
   output logic                    y_valid,
   input  logic                    y_ready,
   output logic [DATA_WIDTH-1:0]   y_data,
   output logic [c_rw-1:0]         y_row
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

   localparam logic [c_kw-1:0] c_k_last   = c_kw'(c_words - 1);
   localparam logic [c_kw-1:0] c_k_one    = c_kw'(1);
   localparam logic [c_aw-1:0] c_aw_one   = c_aw'(1);
   localparam logic [c_rw-1:0] c_row_last = c_rw'(ROWS - 1);
   localparam logic [c_rw-1:0] c_row_one  = c_rw'(1);

   state_t                        r_state;
   logic                          r_issue;
   logic [c_kw-1:0]               r_k;
   logic [c_rw-1:0]               r_row;
   logic signed [ACC_WIDTH-1:0]   r_acc;
   logic signed [ACC_WIDTH-1:0]   w_mac_ext;
   logic signed [ACC_WIDTH-1:0]   w_acc_next;
   logic [ACC_WIDTH-DATA_WIDTH:0] w_acc_hi;
   logic [DATA_WIDTH-1:0]         w_y_sat;

   // r_issue is high exactly in the cycle the memories return issued data
   assign mac_a = r_issue ? w_rdata : '0;
   assign mac_b = r_issue ? x_rdata : '0;

   assign w_mac_ext  = ACC_WIDTH'(signed'(mac_result));
   assign w_acc_next = r_issue ? (r_acc + w_mac_ext) : r_acc;
   assign w_acc_hi   = w_acc_next[ACC_WIDTH-1:DATA_WIDTH-1];

   always_comb begin
      w_y_sat = w_acc_next[DATA_WIDTH-1:0];
      if (!((&w_acc_hi) || (~|w_acc_hi)))
         w_y_sat = w_acc_next[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_issue <= 1'b0;
         r_k     <= '0;
         r_row   <= '0;
         r_acc   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         w_addr  <= '0;
         x_addr  <= '0;
         y_valid <= 1'b0;
         y_data  <= '0;
         y_row   <= '0;
      end else begin
         r_issue <= (r_state == S_RUN);
         done    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_RUN;
                  busy    <= 1'b1;
                  r_row   <= '0;
                  r_k     <= '0;
                  r_acc   <= '0;
                  w_addr  <= '0;
                  x_addr  <= '0;
               end
            end
            S_RUN: begin
               r_acc <= w_acc_next;
               if (r_k == c_k_last) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_k    <= r_k + c_k_one;
                  w_addr <= w_addr + c_aw_one;
                  x_addr <= x_addr + c_k_one;
               end
            end
            S_DRAIN: begin
               r_acc   <= w_acc_next;
               y_data  <= w_y_sat;
               y_row   <= r_row;
               y_valid <= 1'b1;
               r_state <= S_OUT;
            end
            default: begin
               if (y_ready) begin
                  y_valid <= 1'b0;
                  if (r_row == c_row_last) begin
                     r_state <= S_IDLE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     // rows are contiguous, so the held last address plus one starts the next row
                     r_row   <= r_row + c_row_one;
                     r_k     <= '0;
                     r_acc   <= '0;
                     w_addr  <= w_addr + c_aw_one;
                     x_addr  <= '0;
                     r_state <= S_RUN;
                  end
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_matvec_mac4_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matvec_mac4_seq
//  Description : Directed self-checking bench, ROWS=2 VEC_LEN=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matvec_mac4_seq;

   localparam int MAXC = 40;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        busy;
   logic        done;
   logic [1:0]  w_addr;
   logic [63:0] w_rdata;
   logic [0:0]  x_addr;
   logic [63:0] x_rdata;
   logic [63:0] mac_a;
   logic [63:0] mac_b;
   logic [31:0] mac_result;
   logic        y_valid;
   logic        y_ready;
   logic [15:0] y_data;
   logic [0:0]  y_row;

   logic [63:0] wmem [4];
   logic [63:0] xmem [2];

   int checks;
   int errors;

   logic        rv    [MAXC];
   logic        rr    [MAXC];
   logic [15:0] rd    [MAXC];
   logic [0:0]  rrow  [MAXC];
   logic [1:0]  rwa   [MAXC];
   logic [0:0]  rxa   [MAXC];
   logic        rbusy [MAXC];
   int          n_rec;
   int          done_cnt;
   int          done_cyc;

   matvec_mac4_seq #(
      .DATA_WIDTH(16), .VEC_LEN(8), .ROWS(2), .ACC_WIDTH(32)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .w_addr(w_addr), .w_rdata(w_rdata), .x_addr(x_addr), .x_rdata(x_rdata),
      .mac_a(mac_a), .mac_b(mac_b), .mac_result(mac_result),
      .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_row(y_row)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      w_rdata <= wmem[w_addr];
      x_rdata <= xmem[x_addr];
   end

   // external mac4 lane group: sum of the four products, each >>>14
   function automatic logic [31:0] mac4(input logic [63:0] a, input logic [63:0] b);
      logic signed [31:0] p;
      logic signed [31:0] s;
      s = 0;
      for (int i = 0; i < 4; i++) begin
         p = $signed(a[i*16 +: 16]) * $signed(b[i*16 +: 16]);
         s = s + (p >>> 14);
      end
      return s;
   endfunction

   assign mac_result = mac4(mac_a, mac_b);

   task automatic load(input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2,
                       input logic [63:0] w3, input logic [63:0] x0, input logic [63:0] x1);
      wmem[0] = w0; wmem[1] = w1; wmem[2] = w2; wmem[3] = w3;
      xmem[0] = x0; xmem[1] = x1;
   endtask

   // runs one product; cycle n is the cycle after the n-th edge following the start sample
   task automatic run_product(input int stall, input int extra_start);
      int left;
      left     = stall;
      n_rec    = 0;
      done_cnt = 0;
      done_cyc = -1;
      @(negedge clk);
      start   = 1'b1;
      y_ready = 1'b1;
      @(posedge clk);
      for (int n = 0; n < MAXC; n++) begin
         @(negedge clk);
         start = (n == extra_start);
         if (y_valid && left > 0) begin
            y_ready = 1'b0;
            left--;
         end else begin
            y_ready = 1'b1;
         end
         rv[n] = y_valid; rr[n] = y_ready; rd[n] = y_data; rrow[n] = y_row;
         rwa[n] = w_addr; rxa[n] = x_addr; rbusy[n] = busy;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = n;
         end
         n_rec = n + 1;
         if (done_cyc >= 0 && n >= done_cyc + 3) break;
      end
      start   = 1'b0;
      y_ready = 1'b1;
   endtask

   function automatic int hs_at(input int k);
      int seen;
      seen = 0;
      for (int n = 0; n < n_rec; n++)
         if (rv[n] && rr[n]) begin
            if (seen == k) return n;
            seen++;
         end
      return -1;
   endfunction

   task automatic test_reset();
      rst_n = 1'b1; start = 1'b0; y_ready = 1'b1;
      load(0, 0, 0, 0, 0, 0);
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, y_valid} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got %b required 000", {busy, done, y_valid});
      end
      checks++;
      if ({w_addr, x_addr, y_data, y_row} !== '0) begin
         errors++; $display("FAIL reset_outputs: got w%0d x%0d y%0d r%0d required all 0", w_addr, x_addr, y_data, y_row);
      end
      checks++;
      if ({mac_a, mac_b} !== '0) begin
         errors++; $display("FAIL reset_mac: got a=%h b=%h required 0", mac_a, mac_b);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int h0, h1;
      load({4{16'h4000}}, {4{16'h4000}}, {4{16'h4000}}, {4{16'h4000}}, {4{16'h0400}}, {4{16'h0400}});
      run_product(0, -1);
      h0 = hs_at(0); h1 = hs_at(1);
      checks++;
      if (h0 !== 3 || h1 !== 7) begin
         errors++; $display("FAIL basic_hs_cycle: got %0d,%0d required 3,7", h0, h1);
      end
      checks++;
      if (h0 < 0 || h1 < 0 || rd[h0] !== 16'd8192 || rd[h1] !== 16'd8192 || rrow[h0] !== 1'b0 || rrow[h1] !== 1'b1) begin
         errors++; $display("FAIL basic_rows: got row0 %0d row1 %0d required 8192,8192", (h0 < 0) ? -1 : rd[h0], (h1 < 0) ? -1 : rd[h1]);
      end
      checks++;
      if (done_cnt !== 1 || done_cyc !== 8) begin
         errors++; $display("FAIL basic_done: got count %0d cycle %0d required 1 at 8", done_cnt, done_cyc);
      end
   endtask

   task automatic test_saturation();
      int h0, h1;
      load({4{16'h4000}}, {4{16'h4000}}, {4{16'hC000}}, {4{16'hC000}}, {4{16'h2000}}, {4{16'h2000}});
      run_product(0, -1);
      h0 = hs_at(0); h1 = hs_at(1);
      checks++;
      if (h0 < 0 || rd[h0] !== 16'h7FFF) begin
         errors++; $display("FAIL sat_pos: got %h required 7fff", (h0 < 0) ? 16'hxxxx : rd[h0]);
      end
      checks++;
      if (h1 < 0 || rd[h1] !== 16'h8000) begin
         errors++; $display("FAIL sat_neg: got %h required 8000", (h1 < 0) ? 16'hxxxx : rd[h1]);
      end
   endtask

   task automatic test_mixed_addr();
      int exp_wa [8] = '{0, 1, 1, 1, 2, 3, 3, 3};
      int exp_xa [8] = '{0, 1, 1, 1, 0, 1, 1, 1};
      int bad;
      int h0, h1;
      load({4{16'hC000, 16'h4000}}, {4{16'hC000, 16'h4000}}, {4{16'h2000}}, {4{16'h2000}},
           {4{16'h1000}}, {4{16'h1000}});
      run_product(0, -1);
      h0 = hs_at(0); h1 = hs_at(1);
      checks++;
      if (h0 < 0 || rd[h0] !== 16'd0) begin
         errors++; $display("FAIL mixed_row0: got %0d required 0", (h0 < 0) ? -1 : rd[h0]);
      end
      checks++;
      if (h1 < 0 || rd[h1] !== 16'd16384) begin
         errors++; $display("FAIL mixed_row1: got %0d required 16384", (h1 < 0) ? -1 : rd[h1]);
      end
      bad = -1;
      for (int n = 0; n < 8; n++)
         if (bad < 0 && (rwa[n] !== 2'(exp_wa[n]) || rxa[n] !== 1'(exp_xa[n]))) bad = n;
      checks++;
      if (bad >= 0) begin
         errors++; $display("FAIL addr_seq: cycle %0d got w%0d x%0d required w%0d x%0d", bad, rwa[bad], rxa[bad], exp_wa[bad], exp_xa[bad]);
      end
   endtask

   task automatic test_backpressure();
      int bad;
      int h0, h1;
      load({4{16'h4000}}, {4{16'h4000}}, {4{16'h4000}}, {4{16'h4000}}, {4{16'h0400}}, {4{16'h0400}});
      run_product(5, -1);
      bad = -1;
      for (int n = 3; n <= 7; n++)
         if (bad < 0 && (rv[n] !== 1'b1 || rr[n] !== 1'b0 || rd[n] !== 16'd8192 ||
                         rrow[n] !== 1'b0 || rwa[n] !== 2'd1 || rxa[n] !== 1'b1)) bad = n;
      checks++;
      if (bad >= 0) begin
         errors++; $display("FAIL bp_stable: cycle %0d got v%0d d%0d r%0d w%0d required v1 d8192 r0 w1", bad, rv[bad], rd[bad], rrow[bad], rwa[bad]);
      end
      h0 = hs_at(0); h1 = hs_at(1);
      checks++;
      if (h0 !== 8 || h1 !== 12 || done_cyc !== 13) begin
         errors++; $display("FAIL bp_resume: got hs %0d,%0d done %0d required 8,12 done 13", h0, h1, done_cyc);
      end
      checks++;
      if (h1 < 0 || rd[h1] !== 16'd8192 || rrow[h1] !== 1'b1) begin
         errors++; $display("FAIL bp_row1: got %0d required 8192", (h1 < 0) ? -1 : rd[h1]);
      end
   endtask

   task automatic test_start_ignored();
      int h1;
      load({4{16'h4000}}, {4{16'h4000}}, {4{16'h4000}}, {4{16'h4000}}, {4{16'h0400}}, {4{16'h0400}});
      run_product(0, 2);
      h1 = hs_at(1);
      checks++;
      if (done_cnt !== 1 || done_cyc !== 8 || h1 !== 7) begin
         errors++; $display("FAIL start_busy: got done %0d at %0d hs1 %0d required 1 at 8 hs1 7", done_cnt, done_cyc, h1);
      end
      checks++;
      if (done_cyc < 0 || rbusy[done_cyc + 1] !== 1'b0 || rd[7] !== 16'd8192) begin
         errors++; $display("FAIL start_busy_idle: got busy %0d y %0d required 0 and 8192", (done_cyc < 0) ? 1 : rbusy[done_cyc + 1], rd[7]);
      end
   endtask

   task automatic test_reset_midrun();
      int h0, h1;
      load({4{16'h4000}}, {4{16'h4000}}, {4{16'hC000}}, {4{16'hC000}}, {4{16'h2000}}, {4{16'h2000}});
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || w_addr !== 2'd3 || mac_a === 64'd0) begin
         errors++; $display("FAIL midrun_state: got busy %0d w%0d a=%h required busy 1 w3 a nonzero", busy, w_addr, mac_a);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, y_valid, w_addr, x_addr, y_data, y_row, mac_a, mac_b} !== '0) begin
         errors++; $display("FAIL midrun_reset: got busy %0d w%0d x%0d y%0d a=%h required all 0", busy, w_addr, x_addr, y_data, mac_a);
      end
      @(negedge clk); rst_n = 1'b1;
      run_product(0, -1);
      h0 = hs_at(0); h1 = hs_at(1);
      checks++;
      if (h0 !== 3 || rd[h0] !== 16'h7FFF || rrow[h0] !== 1'b0 || h1 !== 7 || rd[h1] !== 16'h8000) begin
         errors++; $display("FAIL midrun_restart: got hs %0d,%0d data %h,%h required 3,7 7fff,8000", h0, h1, (h0 < 0) ? 16'hxxxx : rd[h0], (h1 < 0) ? 16'hxxxx : rd[h1]);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_saturation();
      test_mixed_addr();
      test_backpressure();
      test_start_ignored();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
